// File: rtl/mul_pkg.sv
// Shared opcodes, FSM state encoding and iteration count for the iterative multiplier.
package mul_pkg;

    localparam logic [2:0] MUL_OP_MUL   = 3'b101;
    localparam logic [2:0] MUL_OP_UMULL = 3'b110;
    localparam logic [2:0] MUL_OP_SMULL = 3'b111;

    localparam int MUL_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MUL_OP_MUL) || (op == MUL_OP_UMULL) || (op == MUL_OP_SMULL);
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Combinational 64-bit conditional two's-complement negation; zero latency, no flow control.
module mul_sign_fix (
    input  logic [63:0] i_val,
    input  logic        i_neg,
    output logic [63:0] o_val
);

    assign o_val = i_neg ? (~i_val + 64'd1) : i_val;

endmodule

// File: rtl/mul_unit.sv
// Iterative radix-2 32x32 multiplier (MUL/UMULL/SMULL): 32 Busy cycles then a one-cycle Done;
// Start is ignored while Busy. Define MUL_EARLY_TERM_EN to finish once the multiplier is exhausted.
module mul_unit
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  ALUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] ResultLo,
    output logic [31:0] ResultHi,
    output logic [1:0]  MulFlags
);

    mul_state_t  r_state;
    logic [2:0]  r_op;
    logic        r_sign;
    logic [63:0] r_mcand;
    logic [31:0] r_mplr;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_res_lo;
    logic [31:0] r_res_hi;
    logic [1:0]  r_flags;

    logic        w_start_ok;
    logic        w_is_smull;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [63:0] w_acc_next;
    logic [31:0] w_mplr_next;
    logic        w_last;
    logic [63:0] w_prod;
    logic        w_is_mul;
    logic [31:0] w_res_hi;
    logic        w_flag_n;
    logic        w_flag_z;

    assign w_start_ok  = Start && is_mul_op(ALUControl) && (r_state != ST_BUSY);
    assign w_is_smull  = (ALUControl == MUL_OP_SMULL);
    // SMULL runs as an unsigned magnitude multiply; the sign is restored at the end.
    assign w_op_a      = (w_is_smull && SrcA[31]) ? (~SrcA + 32'd1) : SrcA;
    assign w_op_b      = (w_is_smull && SrcB[31]) ? (~SrcB + 32'd1) : SrcB;
    assign w_acc_next  = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplr_next = {1'b0, r_mplr[31:1]};

`ifdef MUL_EARLY_TERM_EN
    assign w_last = (r_cnt == 5'(MUL_ITERS - 1)) || (w_mplr_next == 32'd0);
`else
    assign w_last = (r_cnt == 5'(MUL_ITERS - 1));
`endif

    mul_sign_fix u_sign_fix (
        .i_val (w_acc_next),
        .i_neg (r_sign),
        .o_val (w_prod)
    );

    assign w_is_mul = (r_op == MUL_OP_MUL);
    assign w_res_hi = w_is_mul ? 32'd0 : w_prod[63:32];
    assign w_flag_n = w_is_mul ? w_prod[31] : w_prod[63];
    assign w_flag_z = w_is_mul ? (w_prod[31:0] == 32'd0) : (w_prod == 64'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_op     <= 3'd0;
            r_sign   <= 1'b0;
            r_mcand  <= 64'd0;
            r_mplr   <= 32'd0;
            r_acc    <= 64'd0;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_res_lo <= 32'd0;
            r_res_hi <= 32'd0;
            r_flags  <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (w_start_ok) begin
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
                        r_op    <= ALUControl;
                        r_sign  <= w_is_smull && (SrcA[31] ^ SrcB[31]);
                        r_mcand <= {32'd0, w_op_a};
                        r_mplr  <= w_op_b;
                        r_acc   <= 64'd0;
                        r_cnt   <= 5'd0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= w_mplr_next;
                    r_cnt   <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_res_lo <= w_prod[31:0];
                        r_res_hi <= w_res_hi;
                        r_flags  <= {w_flag_n, w_flag_z};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign ResultLo = r_res_lo;
    assign ResultHi = r_res_hi;
    assign MulFlags = r_flags;

endmodule
